// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 2 ** AW;

    localparam logic [AW-1:0] X0 = '0;

    // Requester indices; also the encoding of the round-robin priority bit.
    localparam logic REQ_ALU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus between decode/execute/memory stages, the arbiter and the register file.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic            wb0_valid;
    logic [AW-1:0]   wb0_rd;
    logic [XLEN-1:0] wb0_data;
    logic            wb0_ready;
    logic            wb1_valid;
    logic [AW-1:0]   wb1_rd;
    logic [XLEN-1:0] wb1_data;
    logic            wb1_ready;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic            err_spurious;

    // Pipeline side: requesters, decode and observers of the register file port.
    modport master (
        output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
               issue_valid, issue_rd, rs1, rs2,
        input  wb0_ready, wb1_ready, rs1_busy, rs2_busy,
               rf_we, rf_rd, rf_wdata, err_spurious
    );

    // Arbiter side.
    modport slave (
        input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
               issue_valid, issue_rd, rs1, rs2,
        output wb0_ready, wb1_ready, rs1_busy, rs2_busy,
               rf_we, rf_rd, rf_wdata, err_spurious
    );
endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register pending-write scoreboard with spurious-commit detection.
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    input  logic          rf_we,
    input  logic [AW-1:0] rf_rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          err_spurious
);
    logic [NREG-1:0] busy, busy_nxt;

    // Clear on commit first, then set on issue so a newer writer stays pending.
    always_comb begin
        busy_nxt = busy;
        if (rf_we)
            busy_nxt[rf_rd] = 1'b0;
        if (issue_valid)
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[X0] = 1'b0;
    end

    // Busy vector and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= '0;
            err_spurious <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (rf_we && rf_rd != X0 && !busy[rf_rd])
                err_spurious <= 1'b1;
        end
    end

    // Hazard queries; masked during reset.
    always_comb begin
        rs1_busy = !reset && busy[rs1];
        rs2_busy = !reset && busy[rs2];
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter driving the register file's single write port.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    regfile_wb_arbiter_if.slave bus
);
    logic            prio;
    logic            gnt0, gnt1, hs0, hs1;
    wb_req_t         sel;
    logic            rf_we_q;
    logic [AW-1:0]   rf_rd_q;
    logic [XLEN-1:0] rf_wdata_q;

    // Grant the lone requester, or the prioritised one under contention.
    always_comb begin
        gnt0 = bus.wb0_valid && (!bus.wb1_valid || prio == REQ_ALU);
        gnt1 = bus.wb1_valid && (!bus.wb0_valid || prio == REQ_LOAD);
        hs0  = !reset && gnt0;
        hs1  = !reset && gnt1;
        sel  = hs1 ? '{rd: bus.wb1_rd, data: bus.wb1_data}
                   : '{rd: bus.wb0_rd, data: bus.wb0_data};
    end

    assign bus.wb0_ready = hs0;
    assign bus.wb1_ready = hs1;

    // Priority flips away from whoever was just granted.
    always_ff @(posedge clk) begin
        if (reset)
            prio <= REQ_ALU;
        else if (hs0)
            prio <= REQ_LOAD;
        else if (hs1)
            prio <= REQ_ALU;
    end

    // Registered write port; x0 writes are accepted but never reach the file.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= X0;
            rf_wdata_q <= '0;
        end else if (hs0 || hs1) begin
            rf_we_q    <= (sel.rd != X0);
            rf_rd_q    <= sel.rd;
            rf_wdata_q <= sel.data;
        end else begin
            rf_we_q    <= 1'b0;
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_rd    = rf_rd_q;
    assign bus.rf_wdata = rf_wdata_q;

    regfile_scoreboard u_sb (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (bus.issue_valid),
        .issue_rd     (bus.issue_rd),
        .rf_we        (rf_we_q),
        .rf_rd        (rf_rd_q),
        .rs1          (bus.rs1),
        .rs2          (bus.rs2),
        .rs1_busy     (bus.rs1_busy),
        .rs2_busy     (bus.rs2_busy),
        .err_spurious (bus.err_spurious)
    );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus();
    regfile_wb_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Model state
    bit              mbusy [NREG];
    bit              mprio;
    bit              m_we, merr;
    logic [AW-1:0]   m_rd;
    logic [XLEN-1:0] m_wdata;
    bit              m_hs0, m_hs1;

    // Requester-side stimulus
    bit              pend0, pend1, iss_v;
    logic [AW-1:0]   p0rd, p1rd, iss_rd, q1, q2;
    logic [XLEN-1:0] p0data, p1data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        mprio = 1'b0; m_we = 1'b0; m_rd = '0; m_wdata = '0; merr = 1'b0;
    endtask

    // One clock: drive, check combinational outputs, step the model, check registered outputs.
    task automatic tick();
        int g;
        bit              n_we, n_err;
        logic [AW-1:0]   n_rd;
        logic [XLEN-1:0] n_wdata;
        bit              n_busy [NREG];
        bus.wb0_valid = pend0; bus.wb0_rd = p0rd; bus.wb0_data = p0data;
        bus.wb1_valid = pend1; bus.wb1_rd = p1rd; bus.wb1_data = p1data;
        bus.issue_valid = iss_v; bus.issue_rd = iss_rd;
        bus.rs1 = q1; bus.rs2 = q2;
        #1;
        g = -1;
        if (!reset) begin
            if (pend0 && pend1) g = int'(mprio);
            else if (pend0)     g = 0;
            else if (pend1)     g = 1;
        end
        m_hs0 = (g == 0);
        m_hs1 = (g == 1);
        chk("wb0_ready", 32'(bus.wb0_ready), 32'(m_hs0));
        chk("wb1_ready", 32'(bus.wb1_ready), 32'(m_hs1));
        chk("rs1_busy", 32'(bus.rs1_busy), reset ? 32'd0 : 32'(mbusy[q1]));
        chk("rs2_busy", 32'(bus.rs2_busy), reset ? 32'd0 : 32'(mbusy[q2]));
        n_busy = mbusy; n_err = merr; n_we = 1'b0; n_rd = m_rd; n_wdata = m_wdata;
        if (m_we) begin
            if (!mbusy[m_rd]) n_err = 1'b1;
            n_busy[m_rd] = 1'b0;
        end
        if (iss_v && iss_rd != 0) n_busy[iss_rd] = 1'b1;
        if (g >= 0) begin
            n_rd    = (g == 0) ? p0rd : p1rd;
            n_wdata = (g == 0) ? p0data : p1data;
            n_we    = (n_rd != 0);
            mprio   = (g == 0);
        end
        @(posedge clk);
        #1;
        if (reset) model_reset();
        else begin
            mbusy = n_busy; merr = n_err; m_we = n_we; m_rd = n_rd; m_wdata = n_wdata;
        end
        chk("rf_we", 32'(bus.rf_we), 32'(m_we));
        chk("rf_rd", 32'(bus.rf_rd), 32'(m_rd));
        chk("rf_wdata", bus.rf_wdata, m_wdata);
        chk("err_spurious", 32'(bus.err_spurious), 32'(merr));
        if (m_hs0) pend0 = 1'b0;
        if (m_hs1) pend1 = 1'b0;
    endtask

    task automatic idle();
        pend0 = 0; pend1 = 0; iss_v = 0; iss_rd = '0; q1 = '0; q2 = '0;
        p0rd = '0; p1rd = '0; p0data = '0; p1data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1; idle(); tick(); tick(); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        idle();
        tick(); tick();
        reset = 1'b0;

        // Single ALU write with hazard query on rs1.
        q1 = 5'd8; iss_v = 1; iss_rd = 5'd8; tick();
        iss_v = 0; pend0 = 1; p0rd = 5'd8; p0data = 32'h24; tick();
        chk("t1_rf_we", 32'(bus.rf_we), 32'd1);
        chk("t1_rf_wdata", bus.rf_wdata, 32'h24);
        chk("t1_busy_before_commit", 32'(bus.rs1_busy), 32'd1);
        tick();
        chk("t1_busy_after_commit", 32'(bus.rs1_busy), 32'd0);

        // Contention from reset, then a third ALU request behind the waiting load.
        do_reset();
        pend0 = 1; p0rd = 5'd3; p0data = 32'h11;
        pend1 = 1; p1rd = 5'd9; p1data = 32'h22;
        tick();
        chk("t2_first", 32'(bus.rf_rd), 32'd3);
        pend0 = 1; p0rd = 5'd4; p0data = 32'h33;
        tick();
        chk("t2_second", 32'(bus.rf_rd), 32'd9);
        tick();
        chk("t2_third", 32'(bus.rf_rd), 32'd4);
        tick();

        // x0 write from the load path.
        do_reset();
        pend1 = 1; p1rd = 5'd0; p1data = 32'hFFFF_FFFF; tick();
        chk("t3_x0_we", 32'(bus.rf_we), 32'd0);
        tick();
        chk("t3_x0_err", 32'(bus.err_spurious), 32'd0);

        // Set/clear collision on register 5.
        q2 = 5'd5;
        iss_v = 1; iss_rd = 5'd5; tick();
        iss_v = 0; pend0 = 1; p0rd = 5'd5; p0data = 32'h55; tick();
        iss_v = 1; iss_rd = 5'd5; tick();
        iss_v = 0;
        chk("t4_busy_set_wins", 32'(bus.rs2_busy), 32'd1);
        pend1 = 1; p1rd = 5'd5; p1data = 32'h66; tick(); tick();
        chk("t4_busy_cleared", 32'(bus.rs2_busy), 32'd0);
        chk("t4_no_err", 32'(bus.err_spurious), 32'd0);

        // Spurious commit, sticky.
        pend0 = 1; p0rd = 5'd12; p0data = 32'hC; tick(); tick();
        chk("t5_err", 32'(bus.err_spurious), 32'd1);
        tick(); tick();
        chk("t5_err_sticky", 32'(bus.err_spurious), 32'd1);

        // Reset right after a handshake.
        do_reset();
        iss_v = 1; iss_rd = 5'd7; q1 = 5'd7; tick();
        iss_v = 0; pend0 = 1; p0rd = 5'd7; p0data = 32'h77; tick();
        pend0 = 1; pend1 = 1; p0rd = 5'd1; p1rd = 5'd2;
        reset = 1'b1; tick();
        chk("t6_rf_we_dropped", 32'(bus.rf_we), 32'd0);
        reset = 1'b0; pend0 = 1; pend1 = 1; tick();
        chk("t6_prio_reset", 32'(bus.rf_rd), 32'd1);
        tick();

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) do_reset();
            if (!pend0 && $urandom_range(0, 1) == 1) begin
                pend0 = 1; p0rd = AW'($urandom); p0data = $urandom;
            end
            if (!pend1 && $urandom_range(0, 2) == 0) begin
                pend1 = 1; p1rd = AW'($urandom); p1data = $urandom;
            end
            iss_v  = ($urandom_range(0, 1) == 1);
            iss_rd = AW'($urandom);
            q1 = AW'($urandom); q2 = AW'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            tick();
            reset = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
